stream_downsizer: RTL
=====================

// Module: stream_downsizer
// PURPOSE
//  Valid/ready width converter: takes IN_WIDTH words on the slave side and emits
//  them as OUT_WIDTH beats on the master side. Each word carries a beat count, so
//  partial words are supported. Used after the 64-bit stream buffers to feed
//  narrow consumers.
//  s_ready is driven from a register only, and no combinational path runs from
//  m_ready to s_ready. This breaks the reverse (ready) path.
// PARAMETERS
//  IN_WIDTH   64  slave word width; must equal OUT_WIDTH*RATIO
//  OUT_WIDTH  16  master beat width
//  LSB_FIRST  1   1: beat 0 = bits [OUT_WIDTH-1:0]; 0: beat 0 = top OUT_WIDTH bits
//  (derived) RATIO = IN_WIDTH/OUT_WIDTH, must be a power of 2 and >=2 (elaboration error otherwise)
//  (derived) BW = $clog2(RATIO)
// PORTS
//  clk      in   1          clock, all state on rising edge
//  rst_n    in   1          asynchronous, active-low reset
//  s_data   in   IN_WIDTH   wide input word
//  s_beats  in   BW         number of valid beats in the word minus 1 (0..RATIO-1)
//  s_valid  in   1          input word valid
//  s_ready  out  1          input can accept; registered (= !nxt_valid)
//  m_data   out  OUT_WIDTH  current narrow beat
//  m_last   out  1          current beat is the final beat of its word
//  m_valid  out  1          output beat valid (= cur_valid)
//  m_ready  in   1          downstream accepts beat
// BEHAVIOUR
//  State:
//   - cur: cur_valid, cur_data, cur_idx[BW], cur_end[BW]
//   - nxt: nxt_valid, nxt_data, nxt_end[BW]
//  Handshake terms: acc = s_valid & s_ready; take = m_valid & m_ready;
//   fin = take & (cur_idx==cur_end).
//  m_data is the beat cur_idx of cur_data, selected by LSB_FIRST.
//   m_last = cur_valid & (cur_idx==cur_end).
//  Per clock edge:
//   - take & !fin: cur_idx += 1.
//   - fin & nxt_valid: cur <= nxt, cur_idx <= 0, nxt_valid <= 0. acc is impossible here (s_ready=0).
//   - fin & !nxt_valid & acc: cur <= s_data/s_beats, cur_idx <= 0.
//   - fin & !nxt_valid & !acc: cur_valid <= 0.
//   - !cur_valid & acc: cur <= input word. nxt stays empty.
//   - cur_valid & !fin & acc: nxt <= input word.
//  Latency: a word accepted at edge N into an empty block gives m_valid at cycle N+1.
//   There is no combinational s->m path.
//  Throughput:
//   - Full words stream with no bubble between the last beat of one word and beat 0 of the next.
//   - Single-beat words (s_beats=0) sustain 1 word/cycle with s_ready held at 1.
//  Stall: while m_valid & !m_ready, m_data, m_last and cur_idx hold. Once nxt is
//   full, s_ready=0 until nxt moves into cur.
//  Upstream must hold s_data, s_beats and s_valid until acc.
//  Reset (asynchronous, mid-operation included):
//   - Registers: cur_valid=0, nxt_valid=0, cur_idx=0, all data=0.
//   - Outputs: m_valid=0, m_last=0, m_data=0, s_ready=1.
//   - Words in flight are dropped. s_valid while rst_n=0 is ignored.
//  s_beats is carried as-is. Any BW-bit value is legal, so no out-of-range case exists.
// TESTING (IN_WIDTH=64, OUT_WIDTH=16)
//  1 s_data=64'h4444_3333_2222_1111, s_beats=3, m_ready=1, LSB_FIRST=1
//    -> beats 1111,2222,3333,4444 on cycles 1-4; m_last only with 4444.
//  2 Words A,B back-to-back (s_beats=3), m_ready=1
//    -> 8 contiguous beats, m_valid never drops.
//    -> s_ready=0 from the cycle after B is accepted until A's last beat is taken.
//  3 During beat 2222 hold m_ready=0 for 5 cycles, with word C offered
//    -> m_data stays 2222 and m_valid stays 1; C waits with s_ready=0.
//    -> After release, order is 3333,4444, then C's beats.
//  4 Four words with s_beats=0 (data ...AAAA,...BBBB,...), s_valid and m_ready held at 1
//    -> AAAA,BBBB,... one per cycle, each with m_last=1; s_ready stays 1.
//  5 LSB_FIRST=0, word as in test 1, s_beats=1
//    -> beats 4444, then 3333 with m_last=1.
//  6 rst_n low during beat 2222 with nxt full
//    -> m_valid=0 and s_ready=1 immediately; after release, no stale beat is emitted.

Source files
------------

// File: rtl/stream_downsizer.sv
// Valid/ready width converter: splits IN_WIDTH words into OUT_WIDTH beats.
// A two-entry (cur + nxt) buffer keeps s_ready purely registered.
module stream_downsizer #(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 16,
  parameter bit LSB_FIRST = 1'b1,
  localparam int RATIO    = IN_WIDTH / OUT_WIDTH,
  localparam int BW       = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IN_WIDTH-1:0]  s_data,
  input  logic [BW-1:0]        s_beats,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [OUT_WIDTH-1:0] m_data,
  output logic                 m_last,
  output logic                 m_valid,
  input  logic                 m_ready
);

  generate
    if (RATIO < 2 || (RATIO & (RATIO - 1)) != 0 || IN_WIDTH != OUT_WIDTH * RATIO) begin : g_param_err
      $error("stream_downsizer: IN_WIDTH/OUT_WIDTH must be a power of two >= 2");
    end
  endgenerate

  logic                cur_valid_q, cur_valid_d;
  logic [IN_WIDTH-1:0] cur_data_q, cur_data_d;
  logic [BW-1:0]       cur_idx_q, cur_idx_d;
  logic [BW-1:0]       cur_end_q, cur_end_d;
  logic                nxt_valid_q, nxt_valid_d;
  logic [IN_WIDTH-1:0] nxt_data_q, nxt_data_d;
  logic [BW-1:0]       nxt_end_q, nxt_end_d;

  logic acc, take, fin, at_end;

  // Beat gi of the current word, in emission order.
  logic [OUT_WIDTH-1:0] beat_w [RATIO];
  genvar gi;
  generate
    for (gi = 0; gi < RATIO; gi++) begin : g_beat
      if (LSB_FIRST) begin : g_lsb
        assign beat_w[gi] = cur_data_q[gi*OUT_WIDTH +: OUT_WIDTH];
      end else begin : g_msb
        assign beat_w[gi] = cur_data_q[(RATIO-1-gi)*OUT_WIDTH +: OUT_WIDTH];
      end
    end
  endgenerate

  assign s_ready = ~nxt_valid_q;
  assign m_valid = cur_valid_q;
  assign m_data  = beat_w[cur_idx_q];
  assign at_end  = (cur_idx_q == cur_end_q);
  assign m_last  = cur_valid_q & at_end;
  assign acc     = s_valid & s_ready;
  assign take    = m_valid & m_ready;
  assign fin     = take & at_end;

  always_comb begin
    cur_valid_d = cur_valid_q;
    cur_data_d  = cur_data_q;
    cur_idx_d   = cur_idx_q;
    cur_end_d   = cur_end_q;
    nxt_valid_d = nxt_valid_q;
    nxt_data_d  = nxt_data_q;
    nxt_end_d   = nxt_end_q;
    if (fin) begin
      // nxt full implies s_ready=0, so acc cannot coincide with the first branch.
      if (nxt_valid_q) begin
        cur_data_d  = nxt_data_q;
        cur_end_d   = nxt_end_q;
        cur_idx_d   = '0;
        nxt_valid_d = 1'b0;
      end else if (acc) begin
        cur_data_d = s_data;
        cur_end_d  = s_beats;
        cur_idx_d  = '0;
      end else begin
        cur_valid_d = 1'b0;
      end
    end else begin
      if (take) begin
        cur_idx_d = cur_idx_q + 1'b1;
      end
      if (acc) begin
        if (!cur_valid_q) begin
          cur_valid_d = 1'b1;
          cur_data_d  = s_data;
          cur_end_d   = s_beats;
          cur_idx_d   = '0;
        end else begin
          nxt_valid_d = 1'b1;
          nxt_data_d  = s_data;
          nxt_end_d   = s_beats;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_valid_q <= 1'b0;
      cur_data_q  <= '0;
      cur_idx_q   <= '0;
      cur_end_q   <= '0;
      nxt_valid_q <= 1'b0;
      nxt_data_q  <= '0;
      nxt_end_q   <= '0;
    end else begin
      cur_valid_q <= cur_valid_d;
      cur_data_q  <= cur_data_d;
      cur_idx_q   <= cur_idx_d;
      cur_end_q   <= cur_end_d;
      nxt_valid_q <= nxt_valid_d;
      nxt_data_q  <= nxt_data_d;
      nxt_end_q   <= nxt_end_d;
    end
  end

endmodule
